// File: rtl/fwd_pkg_tracker_if.sv
// Forwarding-tracker bus: EX result, LSU response, flush and ID-stage qualifiers in;
// per-stage fwd_t packages, stall/ready and regfile write port out.
interface fwd_pkg_tracker_if #(
    parameter int XLEN = 32
);
    typedef struct packed {
        logic [4:0]      fwd_rd_addr;
        logic [XLEN-1:0] fwd_rd_data;
        logic            fwd_allow;
    } fwd_t;

    logic            i_ex_valid;
    logic [4:0]      i_ex_rd_addr;
    logic            i_ex_rd_wren;
    logic            i_ex_is_load;
    logic [XLEN-1:0] i_ex_result;
    logic            o_ex_ready;
    logic            i_lsu_rvalid;
    logic [XLEN-1:0] i_lsu_rdata;
    logic            i_flush;
    logic            i_id_valid;
    logic            i_id_use_rs1;
    logic            i_id_use_rs2;
    logic [4:0]      i_id_rs1_addr;
    logic [4:0]      i_id_rs2_addr;
    logic            o_id_stall;
    fwd_t            o_mem_fwd_pkg;
    fwd_t            o_wb_fwd_pkg;
    logic            o_rf_wren;
    logic [4:0]      o_rf_waddr;
    logic [XLEN-1:0] o_rf_wdata;

    modport master (
        output i_ex_valid, i_ex_rd_addr, i_ex_rd_wren, i_ex_is_load, i_ex_result,
        output i_lsu_rvalid, i_lsu_rdata, i_flush,
        output i_id_valid, i_id_use_rs1, i_id_use_rs2, i_id_rs1_addr, i_id_rs2_addr,
        input  o_ex_ready, o_id_stall, o_mem_fwd_pkg, o_wb_fwd_pkg,
        input  o_rf_wren, o_rf_waddr, o_rf_wdata
    );

    modport slave (
        input  i_ex_valid, i_ex_rd_addr, i_ex_rd_wren, i_ex_is_load, i_ex_result,
        input  i_lsu_rvalid, i_lsu_rdata, i_flush,
        input  i_id_valid, i_id_use_rs1, i_id_use_rs2, i_id_rs1_addr, i_id_rs2_addr,
        output o_ex_ready, o_id_stall, o_mem_fwd_pkg, o_wb_fwd_pkg,
        output o_rf_wren, o_rf_waddr, o_rf_wdata
    );
endinterface

// File: rtl/fwd_pkg_tracker.sv
// MEM/WB slot tracker producing forwarding packages, load-use stall and regfile write.
// Optional macro FWD_LOAD_BYPASS_EN forwards LSU data in the rvalid cycle itself.
module fwd_pkg_tracker #(
    parameter int XLEN           = 32,
    parameter bit RST_PC_INVALID = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    fwd_pkg_tracker_if.slave  bus
);
    localparam logic [1:0] EMPTY     = 2'd0;
    localparam logic [1:0] LOAD_WAIT = 2'd1;
    localparam logic [1:0] READY     = 2'd2;
    localparam logic [1:0] DRAIN     = 2'd3;

`ifdef FWD_LOAD_BYPASS_EN
    localparam logic BYPASS_EN = 1'b1;
`else
    localparam logic BYPASS_EN = 1'b0;
`endif

    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic [4:0]      mem_rd_r;
    logic            mem_wren_r;
    logic [XLEN-1:0] mem_data_r;
    logic [4:0]      wb_rd_r;
    logic [XLEN-1:0] wb_data_r;
    logic            wb_wren_r;

    logic ex_ready_s;
    logic accept_s;
    logic advance_s;
    logic capture_s;
    logic rvalid_hit_s;
    logic bypass_fwd_s;
    logic hazard_s;
    logic stall_s;

    function automatic logic rd_live(input logic wren, input logic [4:0] rd);
        return wren & (rd != 5'd0);
    endfunction

    function automatic logic src_hit(input logic use_src, input logic [4:0] src, input logic [4:0] rd);
        return use_src & (src == rd);
    endfunction

    // Handshake, hazard and slot-movement qualifiers
    always_comb begin
        ex_ready_s   = (state_r == EMPTY) | (state_r == READY);
        accept_s     = bus.i_ex_valid & ex_ready_s & ~bus.i_flush;
        advance_s    = (state_r == READY) & ~bus.i_flush;
        rvalid_hit_s = (state_r == LOAD_WAIT) & bus.i_lsu_rvalid;
        capture_s    = rvalid_hit_s & ~bus.i_flush;
        // A killed load must not forward its data even when it arrives this cycle
        bypass_fwd_s = BYPASS_EN & capture_s;
        hazard_s     = bus.i_id_valid & (state_r == LOAD_WAIT) & rd_live(mem_wren_r, mem_rd_r)
                     & (src_hit(bus.i_id_use_rs1, bus.i_id_rs1_addr, mem_rd_r)
                      | src_hit(bus.i_id_use_rs2, bus.i_id_rs2_addr, mem_rd_r));
        stall_s      = hazard_s & ~(BYPASS_EN & rvalid_hit_s);
    end

    // MEM slot next-state; flush outranks accept
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            EMPTY, READY: begin
                if (bus.i_flush) begin
                    state_nxt_s = EMPTY;
                end else if (accept_s) begin
                    state_nxt_s = bus.i_ex_is_load ? LOAD_WAIT : READY;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            LOAD_WAIT: begin
                if (bus.i_flush) begin
                    state_nxt_s = bus.i_lsu_rvalid ? EMPTY : DRAIN;
                end else if (bus.i_lsu_rvalid) begin
                    state_nxt_s = READY;
                end else begin
                    state_nxt_s = LOAD_WAIT;
                end
            end
            DRAIN: begin
                if (bus.i_lsu_rvalid) begin
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: state_nxt_s = EMPTY;
        endcase
    end

    // MEM slot state and payload
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r    <= RST_PC_INVALID ? EMPTY : READY;
            mem_rd_r   <= 5'd0;
            mem_wren_r <= 1'b0;
            mem_data_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                mem_rd_r   <= bus.i_ex_rd_addr;
                mem_wren_r <= bus.i_ex_rd_wren;
                mem_data_r <= bus.i_ex_is_load ? '0 : bus.i_ex_result;
            end else if (capture_s) begin
                mem_data_r <= bus.i_lsu_rdata;
            end
        end
    end

    // WB slot: one-cycle copy of a READY MEM slot, cleared when nothing advances
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wb_rd_r   <= 5'd0;
            wb_data_r <= '0;
            wb_wren_r <= 1'b0;
        end else if (advance_s) begin
            wb_rd_r   <= mem_rd_r;
            wb_data_r <= mem_data_r;
            wb_wren_r <= rd_live(mem_wren_r, mem_rd_r);
        end else begin
            wb_rd_r   <= 5'd0;
            wb_data_r <= '0;
            wb_wren_r <= 1'b0;
        end
    end

    // Output packing; MEM package reads zero unless the slot holds a live entry
    always_comb begin
        bus.o_ex_ready   = ex_ready_s;
        bus.o_id_stall   = stall_s;
        bus.o_rf_wren    = wb_wren_r;
        bus.o_rf_waddr   = wb_rd_r;
        bus.o_rf_wdata   = wb_data_r;
        bus.o_wb_fwd_pkg = {wb_rd_r, wb_data_r, wb_wren_r};
        case (state_r)
            READY: begin
                bus.o_mem_fwd_pkg = {mem_rd_r, mem_data_r, rd_live(mem_wren_r, mem_rd_r)};
            end
            LOAD_WAIT: begin
                if (bypass_fwd_s) begin
                    bus.o_mem_fwd_pkg = {mem_rd_r, bus.i_lsu_rdata, rd_live(mem_wren_r, mem_rd_r)};
                end else begin
                    bus.o_mem_fwd_pkg = {mem_rd_r, mem_data_r, 1'b0};
                end
            end
            default: bus.o_mem_fwd_pkg = '0;
        endcase
    end
endmodule

// File: tb/tb_fwd_pkg_tracker.sv
// Self-checking bench for fwd_pkg_tracker: per-cycle vector table, load/flush sequences,
// and a regfile-write scoreboard.
module tb_fwd_pkg_tracker;
`ifdef FWD_LOAD_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic i_clk;
    logic i_rst_n;
    int   checks;
    int   failures;
    bit   mon_en;
    logic [36:0] sb_q[$];
    int   stall_cnt;

    fwd_pkg_tracker_if #(.XLEN(32)) bus ();

    fwd_pkg_tracker #(.XLEN(32), .RST_PC_INVALID(1'b1)) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        exv;
        logic [4:0]  rd;
        logic        wren;
        logic        isld;
        logic [31:0] res;
        logic        idv;
        logic        u1;
        logic [4:0]  r1;
        logic        u2;
        logic [4:0]  r2;
        logic        e_rdy;
        logic        e_stall;
        logic [4:0]  e_maddr;
        logic [31:0] e_mdata;
        logic        e_mallow;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic        e_wallow;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_mem(input string tag, input logic [4:0] a, input logic [31:0] d, input logic al);
        chk({tag, ".mem_addr"},  64'(bus.o_mem_fwd_pkg.fwd_rd_addr), 64'(a));
        chk({tag, ".mem_data"},  64'(bus.o_mem_fwd_pkg.fwd_rd_data), 64'(d));
        chk({tag, ".mem_allow"}, 64'(bus.o_mem_fwd_pkg.fwd_allow),   64'(al));
    endtask

    task automatic chk_wb(input string tag, input logic [4:0] a, input logic [31:0] d, input logic al);
        chk({tag, ".wb_addr"},  64'(bus.o_wb_fwd_pkg.fwd_rd_addr), 64'(a));
        chk({tag, ".wb_data"},  64'(bus.o_wb_fwd_pkg.fwd_rd_data), 64'(d));
        chk({tag, ".wb_allow"}, 64'(bus.o_wb_fwd_pkg.fwd_allow),   64'(al));
        chk({tag, ".rf_wren"},  64'(bus.o_rf_wren),  64'(al));
        chk({tag, ".rf_waddr"}, 64'(bus.o_rf_waddr), 64'(a));
        chk({tag, ".rf_wdata"}, 64'(bus.o_rf_wdata), 64'(d));
    endtask

    task automatic idle();
        bus.i_ex_valid    = 1'b0;
        bus.i_ex_rd_addr  = 5'd0;
        bus.i_ex_rd_wren  = 1'b0;
        bus.i_ex_is_load  = 1'b0;
        bus.i_ex_result   = 32'h0;
        bus.i_lsu_rvalid  = 1'b0;
        bus.i_lsu_rdata   = 32'h0;
        bus.i_flush       = 1'b0;
        bus.i_id_valid    = 1'b0;
        bus.i_id_use_rs1  = 1'b0;
        bus.i_id_use_rs2  = 1'b0;
        bus.i_id_rs1_addr = 5'd0;
        bus.i_id_rs2_addr = 5'd0;
    endtask

    task automatic ex_op(input logic [4:0] rd, input logic wren, input logic isld, input logic [31:0] res);
        bus.i_ex_valid   = 1'b1;
        bus.i_ex_rd_addr = rd;
        bus.i_ex_rd_wren = wren;
        bus.i_ex_is_load = isld;
        bus.i_ex_result  = res;
    endtask

    task automatic to_check();
        @(negedge i_clk);
    endtask

    task automatic next_cyc();
        @(posedge i_clk);
        #1;
    endtask

    // Scoreboard: every regfile write must match the oldest expected write
    always @(negedge i_clk) begin
        if (mon_en && (bus.o_rf_wren === 1'b1)) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL rf_write_unexpected: actual=x%0d/0x%0h expected=none",
                         bus.o_rf_waddr, bus.o_rf_wdata);
            end else begin
                logic [36:0] exp_w;
                exp_w = sb_q.pop_front();
                if ({bus.o_rf_waddr, bus.o_rf_wdata} !== exp_w) begin
                    failures++;
                    $display("FAIL rf_write: actual=x%0d/0x%0h expected=x%0d/0x%0h",
                             bus.o_rf_waddr, bus.o_rf_wdata, exp_w[36:32], exp_w[31:0]);
                end
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        mon_en    = 1'b0;
        stall_cnt = 0;

        //                exv   rd    wren  isld  res        idv   u1    r1    u2    r2    rdy   stall maddr mdata      mal   waddr wdata      wal
        tbl[0] = '{1'b1, 5'd5, 1'b1, 1'b0, 32'h11, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0};
        tbl[1] = '{1'b1, 5'd6, 1'b1, 1'b0, 32'h22, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 1'b0, 5'd5, 32'h11, 1'b1, 5'd0, 32'h0,  1'b0};
        tbl[2] = '{1'b1, 5'd0, 1'b1, 1'b0, 32'h55, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd6, 32'h22, 1'b1, 5'd5, 32'h11, 1'b1};
        tbl[3] = '{1'b1, 5'd9, 1'b0, 1'b0, 32'h99, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h55, 1'b0, 5'd6, 32'h22, 1'b1};
        tbl[4] = '{1'b0, 5'd0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd9, 32'h99, 1'b0, 5'd0, 32'h55, 1'b0};
        tbl[5] = '{1'b0, 5'd0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 5'd9, 32'h99, 1'b0};
        tbl[6] = '{1'b0, 5'd0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0};

        // Reset held two edges while EX offers an instruction
        i_rst_n = 1'b0;
        idle();
        ex_op(5'd3, 1'b1, 1'b0, 32'h33);
        repeat (2) @(posedge i_clk);
        to_check();
        chk("rst_hold.ex_ready", 64'(bus.o_ex_ready), 64'd1);
        chk_mem("rst_hold", 5'd0, 32'h0, 1'b0);
        next_cyc();
        i_rst_n = 1'b1;
        idle();
        mon_en = 1'b1;
        to_check();
        chk("rst.ex_ready", 64'(bus.o_ex_ready), 64'd1);
        chk("rst.id_stall", 64'(bus.o_id_stall), 64'd0);
        chk_mem("rst", 5'd0, 32'h0, 1'b0);
        chk_wb("rst", 5'd0, 32'h0, 1'b0);
        next_cyc();

        // ALU chain, x0 and no-write vectors
        for (int i = 0; i < 7; i++) begin
            idle();
            bus.i_ex_valid    = tbl[i].exv;
            bus.i_ex_rd_addr  = tbl[i].rd;
            bus.i_ex_rd_wren  = tbl[i].wren;
            bus.i_ex_is_load  = tbl[i].isld;
            bus.i_ex_result   = tbl[i].res;
            bus.i_id_valid    = tbl[i].idv;
            bus.i_id_use_rs1  = tbl[i].u1;
            bus.i_id_rs1_addr = tbl[i].r1;
            bus.i_id_use_rs2  = tbl[i].u2;
            bus.i_id_rs2_addr = tbl[i].r2;
            if (tbl[i].exv && tbl[i].e_rdy && tbl[i].wren && (tbl[i].rd != 5'd0) && !tbl[i].isld)
                sb_q.push_back({tbl[i].rd, tbl[i].res});
            to_check();
            chk($sformatf("vec%0d.ex_ready", i), 64'(bus.o_ex_ready), 64'(tbl[i].e_rdy));
            chk($sformatf("vec%0d.id_stall", i), 64'(bus.o_id_stall), 64'(tbl[i].e_stall));
            chk_mem($sformatf("vec%0d", i), tbl[i].e_maddr, tbl[i].e_mdata, tbl[i].e_mallow);
            chk_wb($sformatf("vec%0d", i), tbl[i].e_waddr, tbl[i].e_wdata, tbl[i].e_wallow);
            next_cyc();
        end

        // Load-use on x7 with a second load x10 waiting in EX
        idle();
        ex_op(5'd7, 1'b1, 1'b1, 32'h1234);
        to_check();
        chk("ld7.accept_ready", 64'(bus.o_ex_ready), 64'd1);
        next_cyc();
        for (int k = 0; k < 4; k++) begin
            idle();
            ex_op(5'd10, 1'b1, 1'b1, 32'h0);
            bus.i_id_valid    = 1'b1;
            bus.i_id_use_rs1  = 1'b1;
            bus.i_id_rs1_addr = 5'd7;
            if (k == 3) begin
                bus.i_lsu_rvalid = 1'b1;
                bus.i_lsu_rdata  = 32'hDEADBEEF;
                sb_q.push_back({5'd7, 32'hDEADBEEF});
            end
            to_check();
            chk($sformatf("ld7.wait%0d.ex_ready", k), 64'(bus.o_ex_ready), 64'd0);
            if (bus.o_id_stall === 1'b1) stall_cnt++;
            if (k == 3) begin
                if (BYPASS) chk_mem("ld7.bypass", 5'd7, 32'hDEADBEEF, 1'b1);
                else chk("ld7.rvalid.mem_allow", 64'(bus.o_mem_fwd_pkg.fwd_allow), 64'd0);
            end
            next_cyc();
        end
        chk("ld7.stall_cycles", 64'(stall_cnt), BYPASS ? 64'd3 : 64'd4);
        idle();
        ex_op(5'd10, 1'b1, 1'b1, 32'h0);
        bus.i_id_valid    = 1'b1;
        bus.i_id_use_rs1  = 1'b1;
        bus.i_id_rs1_addr = 5'd7;
        to_check();
        chk_mem("ld7.ready", 5'd7, 32'hDEADBEEF, 1'b1);
        chk("ld7.ready.stall", 64'(bus.o_id_stall), 64'd0);
        chk("ld10.accept_ready", 64'(bus.o_ex_ready), 64'd1);
        next_cyc();
        idle();
        bus.i_id_valid    = 1'b1;
        bus.i_id_use_rs2  = 1'b1;
        bus.i_id_rs2_addr = 5'd10;
        bus.i_id_rs1_addr = 5'd10;
        to_check();
        chk("ld10.rs2.stall", 64'(bus.o_id_stall), 64'd1);
        chk_wb("ld7.wb", 5'd7, 32'hDEADBEEF, 1'b1);
        next_cyc();
        idle();
        bus.i_id_valid    = 1'b1;
        bus.i_id_rs1_addr = 5'd10;
        bus.i_id_rs2_addr = 5'd10;
        to_check();
        chk("ld10.nouse.stall", 64'(bus.o_id_stall), 64'd0);
        next_cyc();
        idle();
        bus.i_lsu_rvalid = 1'b1;
        bus.i_lsu_rdata  = 32'hCAFE0010;
        sb_q.push_back({5'd10, 32'hCAFE0010});
        next_cyc();
        idle();
        to_check();
        chk_mem("ld10.ready", 5'd10, 32'hCAFE0010, 1'b1);
        next_cyc();
        next_cyc();

        // Flush in EMPTY: offered EX entry is dropped
        idle();
        bus.i_flush = 1'b1;
        ex_op(5'd12, 1'b1, 1'b0, 32'h66);
        to_check();
        chk("fl_empty.ex_ready", 64'(bus.o_ex_ready), 64'd1);
        next_cyc();
        idle();
        to_check();
        chk_mem("fl_empty.after", 5'd0, 32'h0, 1'b0);
        next_cyc();

        // Flush in READY: slot killed, no WB transfer
        idle();
        ex_op(5'd13, 1'b1, 1'b0, 32'h13);
        next_cyc();
        idle();
        bus.i_flush = 1'b1;
        to_check();
        chk_mem("fl_ready.during", 5'd13, 32'h13, 1'b1);
        next_cyc();
        idle();
        to_check();
        chk_mem("fl_ready.after", 5'd0, 32'h0, 1'b0);
        chk_wb("fl_ready.after", 5'd0, 32'h0, 1'b0);
        next_cyc();

        // Flush in LOAD_WAIT: DRAIN until the late response, then EMPTY
        idle();
        ex_op(5'd8, 1'b1, 1'b1, 32'h0);
        next_cyc();
        idle();
        bus.i_flush = 1'b1;
        ex_op(5'd11, 1'b1, 1'b0, 32'h77);
        to_check();
        chk("fl_lw.flush.ex_ready", 64'(bus.o_ex_ready), 64'd0);
        next_cyc();
        idle();
        ex_op(5'd11, 1'b1, 1'b0, 32'h77);
        to_check();
        chk("fl_lw.drain1.ex_ready", 64'(bus.o_ex_ready), 64'd0);
        chk_mem("fl_lw.drain1", 5'd0, 32'h0, 1'b0);
        next_cyc();
        idle();
        ex_op(5'd11, 1'b1, 1'b0, 32'h77);
        bus.i_lsu_rvalid = 1'b1;
        bus.i_lsu_rdata  = 32'h0000AAAA;
        to_check();
        chk("fl_lw.drain2.ex_ready", 64'(bus.o_ex_ready), 64'd0);
        chk_mem("fl_lw.drain2", 5'd0, 32'h0, 1'b0);
        next_cyc();
        idle();
        ex_op(5'd11, 1'b1, 1'b0, 32'h77);
        sb_q.push_back({5'd11, 32'h77});
        to_check();
        chk("fl_lw.empty.ex_ready", 64'(bus.o_ex_ready), 64'd1);
        chk_mem("fl_lw.empty", 5'd0, 32'h0, 1'b0);
        next_cyc();
        idle();
        to_check();
        chk_mem("fl_lw.x11", 5'd11, 32'h77, 1'b1);
        next_cyc();
        idle();
        to_check();
        chk_wb("fl_lw.x11", 5'd11, 32'h77, 1'b1);
        next_cyc();

        // Flush together with rvalid in LOAD_WAIT: straight to EMPTY
        idle();
        ex_op(5'd14, 1'b1, 1'b1, 32'h0);
        next_cyc();
        idle();
        bus.i_flush      = 1'b1;
        bus.i_lsu_rvalid = 1'b1;
        bus.i_lsu_rdata  = 32'h0000BBBB;
        to_check();
        chk("fl_rv.mem_allow", 64'(bus.o_mem_fwd_pkg.fwd_allow), 64'd0);
        next_cyc();
        idle();
        to_check();
        chk("fl_rv.ex_ready", 64'(bus.o_ex_ready), 64'd1);
        chk_mem("fl_rv.after", 5'd0, 32'h0, 1'b0);
        chk_wb("fl_rv.after", 5'd0, 32'h0, 1'b0);
        next_cyc();
        idle();
        to_check();
        chk_wb("fl_rv.after2", 5'd0, 32'h0, 1'b0);
        next_cyc();

        // Reset mid-load: the stale response is ignored
        idle();
        ex_op(5'd15, 1'b1, 1'b1, 32'h0);
        next_cyc();
        idle();
        i_rst_n = 1'b0;
        next_cyc();
        i_rst_n = 1'b1;
        bus.i_lsu_rvalid = 1'b1;
        bus.i_lsu_rdata  = 32'h0000EEEE;
        to_check();
        chk("rst_mid.ex_ready", 64'(bus.o_ex_ready), 64'd1);
        chk_mem("rst_mid", 5'd0, 32'h0, 1'b0);
        next_cyc();
        idle();
        to_check();
        chk("rst_mid.after.ex_ready", 64'(bus.o_ex_ready), 64'd1);
        chk_mem("rst_mid.after", 5'd0, 32'h0, 1'b0);
        next_cyc();

        idle();
        repeat (3) next_cyc();
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fwd_pkg_tracker.md
Name: fwd_pkg_tracker

Overview:
- Producer side of the forwarding interface: tracks the MEM and WB pipeline slots after EX.
- Emits one fwd_t package per stage: {fwd_rd_addr[4:0], fwd_rd_data[31:0], fwd_allow}.
- Owns load-data return, load-use stall generation and the regfile write port.
- Sits between the EX result bus, the LSU response and the ID-stage forwarding consumer.

Parameters:
- XLEN, 32, data width; fwd_t data field is XLEN bits.
- RST_PC_INVALID, 1, 1 = slots reset to invalid (kept for bench override only; must be 1 in synthesis).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_ex_valid  in  1  EX result presented
- i_ex_rd_addr  in  5  destination register
- i_ex_rd_wren  in  1  instruction writes rd
- i_ex_is_load  in  1  result comes from LSU, not i_ex_result
- i_ex_result  in  XLEN  ALU/MUL result
- o_ex_ready  out  1  MEM slot accepts EX this cycle
- i_lsu_rvalid  in  1  load data valid (1-cycle pulse)
- i_lsu_rdata  in  XLEN  load data
- i_flush  in  1  kill MEM slot (branch/trap redirect)
- i_id_valid, i_id_use_rs1, i_id_use_rs2  in  1 each  ID-stage qualifiers
- i_id_rs1_addr, i_id_rs2_addr  in  5 each  ID sources
- o_id_stall  out  1  load-use hazard: hold ID/EX
- o_mem_fwd_pkg  out  fwd_t  MEM-slot package
- o_wb_fwd_pkg  out  fwd_t  WB-slot package
- o_rf_wren  out  1  regfile write enable
- o_rf_waddr  out  5
- o_rf_wdata  out  XLEN

Behaviour:
- Reset: synchronous and active-low. On any i_clk edge with i_rst_n=0: MEM FSM=EMPTY, WB valid=0, all package fields 0, o_rf_wren=0, o_id_stall=0, o_ex_ready=1. Reset mid-load discards the outstanding response state; any later rvalid with FSM≠LOAD_WAIT/DRAIN is ignored.
- MEM FSM states and transitions:
  - EMPTY: accepting EX with is_load=1 → LOAD_WAIT; accepting EX with is_load=0 → READY.
  - LOAD_WAIT: on rvalid, capture rdata → READY.
  - READY: advances to WB unconditionally next edge; loads new EX or goes to EMPTY.
  - DRAIN: on rvalid, discard data → EMPTY.
- o_ex_ready = (state==EMPTY) | (state==READY); combinational.
- Transfer occurs on i_ex_valid & o_ex_ready.
- i_flush (highest priority over accept, same edge):
  - EMPTY/READY → EMPTY, no WB transfer.
  - LOAD_WAIT → DRAIN, or → EMPTY if rvalid is in the same cycle.
  - EX entry offered in a flush cycle is not accepted.
- MEM package:
  - fwd_rd_addr = slot rd.
  - fwd_rd_data = slot data.
  - fwd_allow = (state==READY) & wren & rd≠0.
  - All zero in EMPTY/DRAIN.
- WB slot: registered copy of MEM when MEM READY advances (1-cycle latency). Valid for exactly one cycle unless refilled.
- o_rf_* driven from the WB slot with o_rf_wren = valid & wren & rd≠0.
- WB package mirrors o_rf_*; fwd_allow = o_rf_wren.
- o_id_stall = i_id_valid & (state∈{LOAD_WAIT}, or EX-accepting a load this cycle is NOT counted) & wren & rd≠0 & ((use_rs1 & rs1==rd) | (use_rs2 & rs2==rd)). Combinational.
- Simultaneous READY-advance and EX accept: both happen in the same edge; throughput 1/cycle for ALU ops.
- Back-to-back load: the second load waits in EX (o_ex_ready=0) until the first is READY.

Optional Feature:
- Macro: FWD_LOAD_BYPASS_EN
- Defined: in LOAD_WAIT with i_lsu_rvalid=1, the MEM package asserts fwd_allow with fwd_rd_data=i_lsu_rdata in the same cycle, and o_id_stall is suppressed for that cycle.
- Undefined: load data is forwardable only from the cycle after capture (READY); stall persists through the rvalid cycle.

Test Plan:
- Reset: hold i_rst_n=0 two edges with i_ex_valid=1 → all packages 0, o_rf_wren=0, o_ex_ready=1 after release.
- ALU chain: EX x5=0x11 then x6=0x22 on consecutive cycles → MEM pkg {5,0x11,1} then {6,0x22,1}; WB pkg {5,0x11,1} one cycle later; o_rf_wren pulses for each.
- Load-use: load x7; ID rs1=7, use_rs1=1; rvalid after 3 cycles with 0xDEADBEEF → o_id_stall=1 for 3 cycles (4 without the macro); MEM pkg {7,0xDEADBEEF,1}.
- x0 / no-write: EX rd=0 result 0x55, and rd=9 wren=0 → fwd_allow=0 in both packages, o_rf_wren=0.
- Flush in LOAD_WAIT: load x8, flush next cycle; rvalid=0xAAAA arrives 2 cycles later → DRAIN, o_ex_ready=0 until then, no rf write of x8, EMPTY afterwards.
- Flush with same-cycle rvalid: load in LOAD_WAIT, i_flush=1 and rvalid=1 together → EMPTY next cycle, o_ex_ready=1, no WB transfer.
